pc_fetch_sequencer: RTL and testbench

- Owns the program counter of the 5-stage MIPS pipeline and sequences instruction fetch.
- Each cycle it selects the next PC: sequential PC+4, a taken-branch target (sign-extended immediate shifted left two, added to PC+4), or a jump target.
- Drives the IF-stage instruction-memory request handshake, applies stalls from the hazard unit, and generates IF/ID flushes on redirect.
- Sits between the hazard/branch-resolve logic and instruction memory, replacing the loose PC mux/adder glue.

---
 rtl/mips_pipe_pkg.sv | 25 ++
 rtl/pc_target_calc.sv | 23 ++
 rtl/pc_fetch_sequencer.sv | 105 ++++++++++
 tb/tb_pc_fetch_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types for the fetch front end: address width, reset PC,
// sequencer state encoding and the next-PC select.
package mips_pipe_pkg;

    localparam int          PIPE_ADDR_W  = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } fsm_state_t;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_HOLD   = 2'd3
    } pc_sel_t;

    // Word offset to byte offset; the two bits shifted out are dropped.
    function automatic logic [PIPE_ADDR_W-1:0] sl2(input logic [PIPE_ADDR_W-1:0] v);
        return {v[PIPE_ADDR_W-3:0], 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target formation: branch (PC+4 + offset*4) and
// J-type jump (upper PC+4 nibble, instr_index, word alignment).
module pc_target_calc
    import mips_pipe_pkg::*;
#(
    parameter int ADDR_W = PIPE_ADDR_W
) (
    input  logic [ADDR_W-1:0] br_pc4_i,
    input  logic [ADDR_W-1:0] br_imm_i,
    input  logic [ADDR_W-1:0] jmp_pc4_i,
    input  logic [25:0]       jmp_idx_i,
    output logic [ADDR_W-1:0] br_target_o,
    output logic [ADDR_W-1:0] jmp_target_o
);

    // Carry out of the top bit falls off naturally at ADDR_W width.
    assign br_target_o  = br_pc4_i + sl2(br_imm_i);
    assign jmp_target_o = {jmp_pc4_i[ADDR_W-1:ADDR_W-4], jmp_idx_i, 2'b00};

    logic unused_pc4_low;
    assign unused_pc4_low = ^jmp_pc4_i[ADDR_W-5:0];

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner for the 5-stage MIPS pipeline: next-PC selection,
// instruction-fetch request, IF/ID and ID/EX flush generation, redirect count.
module pc_fetch_sequencer
    import mips_pipe_pkg::*;
#(
    parameter int                 ADDR_W   = PIPE_ADDR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEF,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              br_valid_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_pc4_i,
    input  logic [ADDR_W-1:0] br_imm_i,
    input  logic              jmp_valid_i,
    input  logic [ADDR_W-1:0] jmp_pc4_i,
    input  logic [25:0]       jmp_idx_i,
    output logic              imem_req_o,
    input  logic              imem_gnt_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              if_flush_o,
    output logic              id_flush_o,
    output logic [CNT_W-1:0]  redirect_cnt_o
);

    fsm_state_t        state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] br_target, jmp_target;
    pc_sel_t           pc_sel;
    logic              redirect;

    pc_target_calc #(
        .ADDR_W(ADDR_W)
    ) u_target (
        .br_pc4_i    (br_pc4_i),
        .br_imm_i    (br_imm_i),
        .jmp_pc4_i   (jmp_pc4_i),
        .jmp_idx_i   (jmp_idx_i),
        .br_target_o (br_target),
        .jmp_target_o(jmp_target)
    );

    assign pc_plus4_o = pc_q + ADDR_W'(4);

    // The resolving branch is older than the decoded jump, so it wins.
    always_comb begin
        pc_sel     = PC_HOLD;
        imem_req_o = 1'b0;
        if_flush_o = 1'b0;
        id_flush_o = 1'b0;
        if (state_q == S_RUN) begin
            if (br_valid_i && br_taken_i) begin
                pc_sel     = PC_BRANCH;
                if_flush_o = 1'b1;
                id_flush_o = 1'b1;
            end else if (jmp_valid_i) begin
                pc_sel     = PC_JUMP;
                if_flush_o = 1'b1;
            end else if (!stall_i) begin
                imem_req_o = 1'b1;
                pc_sel     = imem_gnt_i ? PC_SEQ : PC_HOLD;
            end
        end
    end

    always_comb begin
        pc_d = pc_q;
        unique case (pc_sel)
            PC_SEQ:    pc_d = pc_plus4_o;
            PC_BRANCH: pc_d = br_target;
            PC_JUMP:   pc_d = jmp_target;
            PC_HOLD:   pc_d = pc_q;
            default:   pc_d = pc_q;
        endcase
    end

    assign redirect = (pc_sel == PC_BRANCH) || (pc_sel == PC_JUMP);

    always_comb begin
        cnt_d = cnt_q;
        if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= S_RUN;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_o           = pc_q;
    assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed vector bench for pc_fetch_sequencer: boot cycle, sequential fetch,
// grant back-pressure, stall, branch/jump priority, PC wrap, counter saturation, reset.
module tb_pc_fetch_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, br_valid_i, br_taken_i, jmp_valid_i, imem_gnt_i;
    logic [31:0] br_pc4_i, br_imm_i, jmp_pc4_i;
    logic [25:0] jmp_idx_i;
    logic        imem_req_o, if_flush_o, id_flush_o;
    logic [31:0] pc_o, pc_plus4_o;
    logic [15:0] redirect_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    pc_fetch_sequencer dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .br_valid_i    (br_valid_i),
        .br_taken_i    (br_taken_i),
        .br_pc4_i      (br_pc4_i),
        .br_imm_i      (br_imm_i),
        .jmp_valid_i   (jmp_valid_i),
        .jmp_pc4_i     (jmp_pc4_i),
        .jmp_idx_i     (jmp_idx_i),
        .imem_req_o    (imem_req_o),
        .imem_gnt_i    (imem_gnt_i),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .if_flush_o    (if_flush_o),
        .id_flush_o    (id_flush_o),
        .redirect_cnt_o(redirect_cnt_o)
    );

    typedef struct {
        logic        stall, br_v, br_t;
        logic [31:0] br_pc4, br_imm;
        logic        jv;
        logic [31:0] jpc4;
        logic [25:0] jidx;
        logic        gnt;
        logic        e_req, e_if, e_id;
        logic [31:0] e_pc;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall_i     = v.stall;
        br_valid_i  = v.br_v;
        br_taken_i  = v.br_t;
        br_pc4_i    = v.br_pc4;
        br_imm_i    = v.br_imm;
        jmp_valid_i = v.jv;
        jmp_pc4_i   = v.jpc4;
        jmp_idx_i   = v.jidx;
        imem_gnt_i  = v.gnt;
    endtask

    task automatic idle_inputs();
        stall_i = 0; br_valid_i = 0; br_taken_i = 0; br_pc4_i = 0; br_imm_i = 0;
        jmp_valid_i = 0; jmp_pc4_i = 0; jmp_idx_i = 0; imem_gnt_i = 0;
    endtask

    initial begin
        logic [31:0] cur_pc;
        logic [15:0] exp_cnt;

        //        stall br_v br_t br_pc4        br_imm        jv  jpc4          jidx          gnt req if id  e_pc          e_cnt
        vecs[0]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        26'h0,        1'b1,1'b1,1'b0,1'b0,32'h0000_0004,16'd0};
        vecs[1]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        26'h0,        1'b1,1'b1,1'b0,1'b0,32'h0000_0008,16'd0};
        vecs[2]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        26'h0,        1'b1,1'b1,1'b0,1'b0,32'h0000_000C,16'd0};
        vecs[3]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        26'h0,        1'b1,1'b1,1'b0,1'b0,32'h0000_0010,16'd0};
        vecs[4]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        26'h0,        1'b0,1'b1,1'b0,1'b0,32'h0000_0010,16'd0};
        vecs[5]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        26'h0,        1'b0,1'b1,1'b0,1'b0,32'h0000_0010,16'd0};
        vecs[6]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        26'h0,        1'b0,1'b1,1'b0,1'b0,32'h0000_0010,16'd0};
        vecs[7]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        26'h0,        1'b1,1'b1,1'b0,1'b0,32'h0000_0014,16'd0};
        // stall with gnt high: grant must be ignored
        vecs[8]  = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        26'h0,        1'b1,1'b0,1'b0,1'b0,32'h0000_0014,16'd0};
        // branch resolved not-taken falls through to normal fetch
        vecs[9]  = '{1'b0,1'b1,1'b0,32'h0000_0040,32'hFFFF_FFFE,1'b0,32'h0,        26'h0,        1'b1,1'b1,1'b0,1'b0,32'h0000_0018,16'd0};
        vecs[10] = '{1'b0,1'b1,1'b1,32'h0000_0040,32'hFFFF_FFFE,1'b0,32'h0,        26'h0,        1'b1,1'b0,1'b1,1'b1,32'h0000_0038,16'd1};
        // branch + jump + stall together: branch wins
        vecs[11] = '{1'b1,1'b1,1'b1,32'h0000_0100,32'h0000_0003,1'b1,32'h0000_0000,26'h010_0000,1'b1,1'b0,1'b1,1'b1,32'h0000_010C,16'd2};
        vecs[12] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'h8000_0010,26'h000_0100,1'b1,1'b0,1'b1,1'b0,32'h8000_0400,16'd3};
        // jump overrides stall, lands on the last word
        vecs[13] = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,32'hF000_0000,26'h3FF_FFFF,1'b0,1'b0,1'b1,1'b0,32'hFFFF_FFFC,16'd4};
        vecs[14] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        26'h0,        1'b1,1'b1,1'b0,1'b0,32'h0000_0000,16'd4};
        // offset bits shifted past bit 31 are dropped: 0x10 + 0x4 = 0x14
        vecs[15] = '{1'b0,1'b1,1'b1,32'h0000_0010,32'h4000_0001,1'b0,32'h0,        26'h0,        1'b0,1'b0,1'b1,1'b1,32'h0000_0014,16'd5};
        vecs[16] = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0,32'h0,        26'h0,        1'b0,1'b0,1'b0,1'b0,32'h0000_0014,16'd5};

        idle_inputs();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("reset_pc", pc_o, 32'h0);
        chk("reset_cnt", {16'h0, redirect_cnt_o}, 32'h0);

        // Boot cycle: redirect and fetch inputs must be ignored.
        @(negedge clk_i);
        rst_i = 1'b1;
        br_valid_i = 1; br_taken_i = 1; br_pc4_i = 32'h40; jmp_valid_i = 1;
        jmp_idx_i = 26'h40; imem_gnt_i = 1;
        #1;
        chk("boot_req", {31'h0, imem_req_o}, 32'h0);
        chk("boot_if_flush", {31'h0, if_flush_o}, 32'h0);
        chk("boot_id_flush", {31'h0, id_flush_o}, 32'h0);
        chk("boot_pc", pc_o, 32'h0);
        @(posedge clk_i); #1;
        chk("boot_pc_held", pc_o, 32'h0);
        chk("boot_cnt", {16'h0, redirect_cnt_o}, 32'h0);

        cur_pc = 32'h0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_req", i), {31'h0, imem_req_o}, {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d_if_flush", i), {31'h0, if_flush_o}, {31'h0, vecs[i].e_if});
            chk($sformatf("v%0d_id_flush", i), {31'h0, id_flush_o}, {31'h0, vecs[i].e_id});
            chk($sformatf("v%0d_pc_plus4", i), pc_plus4_o, cur_pc + 32'd4);
            @(posedge clk_i); #1;
            chk($sformatf("v%0d_pc", i), pc_o, vecs[i].e_pc);
            chk($sformatf("v%0d_cnt", i), {16'h0, redirect_cnt_o}, {16'h0, vecs[i].e_cnt});
            $display("vec %0d: pc=%h cnt=%0d", i, pc_o, redirect_cnt_o);
            cur_pc = vecs[i].e_pc;
        end

        // Saturation: 65538 back-to-back jumps on top of 5 earlier redirects.
        @(negedge clk_i);
        idle_inputs();
        jmp_valid_i = 1; jmp_pc4_i = 32'h0; jmp_idx_i = 26'h40;
        exp_cnt = 16'd5;
        for (int n = 1; n <= 65538; n++) begin
            @(posedge clk_i);
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (n == 65529 || n == 65530 || n == 65538) begin
                #1;
                chk($sformatf("sat_cnt_%0d", n), {16'h0, redirect_cnt_o}, {16'h0, exp_cnt});
                $display("saturation after %0d jumps: cnt=%h", n, redirect_cnt_o);
            end
        end
        #1;
        chk("sat_pc", pc_o, 32'h0000_0100);

        // Asynchronous reset away from any clock edge.
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk("async_rst_pc", pc_o, 32'h0);
        chk("async_rst_cnt", {16'h0, redirect_cnt_o}, 32'h0);
        chk("async_rst_req", {31'h0, imem_req_o}, 32'h0);
        chk("async_rst_if_flush", {31'h0, if_flush_o}, 32'h0);
        $display("async reset: pc=%h cnt=%h", pc_o, redirect_cnt_o);

        @(negedge clk_i);
        rst_i = 1'b1;
        idle_inputs();
        imem_gnt_i = 1;
        #1;
        chk("reboot_req", {31'h0, imem_req_o}, 32'h0);
        @(posedge clk_i); #1;
        chk("reboot_pc", pc_o, 32'h0);
        @(negedge clk_i); #1;
        chk("reboot_run_req", {31'h0, imem_req_o}, 32'h1);
        @(posedge clk_i); #1;
        chk("reboot_run_pc", pc_o, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
